// File: rtl/cpu_program_loader.sv
// cpu_program_loader
//   Receives bytes from uart_rx, assembles them little-endian into
//   WORD_BYTES-wide words and writes data words into instruction RAM while
//   a load session holds the CPU paused. Command words (top byte 0xFF) open
//   and close sessions and relocate the write address.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     Defined   - an 8-bit XOR over every byte of every data word in the
//                 session is compared with the low byte K of END_*. A
//                 mismatch flags load_error and suppresses reset_PC.
//     Undefined - K is ignored. load_error reports address overflow only.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   HALT_flag           CPU halted; low acts as a soft reset of the loader
//   packet_ready        byte valid from uart_rx
//   uart_packet[7:0]    received byte
//   packet_ack          four-phase byte-consumed handshake back to uart_rx
//   data_ack            iRAM accepted the current write
//   PC_addr             CPU program counter, watched while PC reset pending
//   cpu_paused          load session active, CPU must not run
//   reset_PC            request to clear the PC
//   iRAM_write_enable   iRAM write strobe
//   extern_iRAM_addr    iRAM write address
//   iRAM_data_in        iRAM write data
//   load_error          sticky session error
//   words_loaded        data words written in this session
module cpu_program_loader #(
   parameter int WORD_BYTES = 3,
   parameter int ADDR_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    HALT_flag,
   input  logic                    packet_ready,
   input  logic [7:0]              uart_packet,
   output logic                    packet_ack,
   input  logic                    data_ack,
   input  logic [ADDR_W-1:0]       PC_addr,
   output logic                    cpu_paused,
   output logic                    reset_PC,
   output logic                    iRAM_write_enable,
   output logic [ADDR_W-1:0]       extern_iRAM_addr,
   output logic [8*WORD_BYTES-1:0] iRAM_data_in,
   output logic                    load_error,
   output logic [ADDR_W:0]         words_loaded
);

   localparam int W     = 8 * WORD_BYTES;
   localparam int CNT_W = $clog2(WORD_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WRITE, S_FINISH} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  byte_cnt_q;
   logic [W-1:0]      word_q;
   logic              packet_ack_q;
   logic              session_q;
   logic              full_q;
   logic [ADDR_W-1:0] addr_q;
   logic [W-1:0]      data_q;
   logic              we_q;
   logic              cpu_paused_q;
   logic              reset_pc_q;
   logic              load_error_q;
   logic [ADDR_W:0]   words_q;

   // Command classification of the assembled word.
   logic is_cmd, is_start, is_set_addr, is_end_reset, is_end_keep;
   assign is_cmd       = (word_q[W-1 -: 8] == 8'hFF);
   assign is_start     = is_cmd && (word_q[W-9 -: 8] == 8'h00);
   assign is_set_addr  = is_cmd && (word_q[W-9 -: 8] == 8'hA0);
   assign is_end_reset = is_cmd && (word_q[W-9 -: 8] == 8'hFF);
   assign is_end_keep  = is_cmd && (word_q[W-9 -: 8] == 8'hF0);

   logic checksum_ok;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] checksum_q;
   logic [7:0] checksum_d;
   logic [7:0] byte_xor [WORD_BYTES+1];

   // XOR fold of all bytes of the word currently being decoded.
   assign byte_xor[0] = 8'h00;
   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_xor
      assign byte_xor[gi+1] = byte_xor[gi] ^ word_q[gi*8 +: 8];
   end
   assign checksum_d  = checksum_q ^ byte_xor[WORD_BYTES];
   assign checksum_ok = (word_q[7:0] == checksum_q);
`else
   assign checksum_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         byte_cnt_q   <= '0;
         word_q       <= '0;
         packet_ack_q <= 1'b0;
         session_q    <= 1'b0;
         full_q       <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
         cpu_paused_q <= 1'b0;
         reset_pc_q   <= 1'b0;
         load_error_q <= 1'b0;
         words_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
         checksum_q   <= 8'h00;
`endif
      end else if (!HALT_flag) begin
         // Soft reset: a pending write is abandoned without advancing the
         // address; error flag, word count and address survive.
         state_q      <= S_IDLE;
         byte_cnt_q   <= '0;
         packet_ack_q <= 1'b0;
         session_q    <= 1'b0;
         we_q         <= 1'b0;
         cpu_paused_q <= 1'b0;
         reset_pc_q   <= 1'b0;
      end else begin
         // Handshake release runs in every state so uart_rx never stalls.
         if (packet_ack_q && !packet_ready)
            packet_ack_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (packet_ready && !packet_ack_q) begin
                  // Shift in from the top: after WORD_BYTES bytes the
                  // first byte sits in bits [7:0].
                  word_q       <= {uart_packet, word_q[W-1:8]};
                  packet_ack_q <= 1'b1;
                  if (byte_cnt_q == CNT_W'(WORD_BYTES - 1)) begin
                     byte_cnt_q <= '0;
                     state_q    <= S_DECODE;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                  end
               end
            end

            S_DECODE: begin
               state_q <= S_IDLE;
               if (is_start) begin
                  session_q    <= 1'b1;
                  cpu_paused_q <= 1'b1;
                  addr_q       <= '0;
                  full_q       <= 1'b0;
                  words_q      <= '0;
                  load_error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  checksum_q   <= 8'h00;
`endif
               end else if (session_q) begin
                  if (is_set_addr) begin
                     addr_q <= word_q[ADDR_W-1:0];
                     full_q <= 1'b0;
                  end else if (is_end_reset || is_end_keep) begin
                     session_q  <= 1'b0;
                     reset_pc_q <= is_end_reset && checksum_ok;
                     if (!checksum_ok)
                        load_error_q <= 1'b1;
                     state_q    <= S_FINISH;
                  end else begin
`ifdef LOADER_CHECKSUM_EN
                     checksum_q <= checksum_d;
`endif
                     if (full_q) begin
                        load_error_q <= 1'b1;
                     end else begin
                        data_q  <= word_q;
                        we_q    <= 1'b1;
                        state_q <= S_WRITE;
                     end
                  end
               end
            end

            S_WRITE: begin
               if (data_ack) begin
                  we_q    <= 1'b0;
                  words_q <= words_q + (ADDR_W+1)'(1);
                  // The top address is written once, then the loader
                  // refuses further data instead of wrapping to 0.
                  if (&addr_q)
                     full_q <= 1'b1;
                  else
                     addr_q <= addr_q + ADDR_W'(1);
                  state_q <= S_IDLE;
               end
            end

            S_FINISH: begin
               if (!reset_pc_q || (PC_addr == '0)) begin
                  cpu_paused_q <= 1'b0;
                  reset_pc_q   <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign packet_ack        = packet_ack_q;
   assign cpu_paused        = cpu_paused_q;
   assign reset_PC          = reset_pc_q;
   assign iRAM_write_enable = we_q;
   assign extern_iRAM_addr  = addr_q;
   assign iRAM_data_in      = data_q;
   assign load_error        = load_error_q;
   assign words_loaded      = words_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader
//   Directed bench for cpu_program_loader (WORD_BYTES=3, ADDR_W=8) with a
//   behavioural iRAM and a byte-level four-phase UART driver.
module tb_cpu_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        HALT_flag;
   logic        packet_ready;
   logic [7:0]  uart_packet;
   logic        packet_ack;
   logic        data_ack;
   logic [7:0]  PC_addr;
   logic        cpu_paused;
   logic        reset_PC;
   logic        iRAM_write_enable;
   logic [7:0]  extern_iRAM_addr;
   logic [23:0] iRAM_data_in;
   logic        load_error;
   logic [8:0]  words_loaded;

   int checks = 0;
   int errors = 0;

   logic [23:0] mem [256];
   int          write_cnt = 0;
   int          ack_rises = 0;
   logic        ack_prev = 1'b0;
   logic        reset_pc_seen = 1'b0;

   always #5 clk = ~clk;

   cpu_program_loader #(.WORD_BYTES(3), .ADDR_W(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .HALT_flag         (HALT_flag),
      .packet_ready      (packet_ready),
      .uart_packet       (uart_packet),
      .packet_ack        (packet_ack),
      .data_ack          (data_ack),
      .PC_addr           (PC_addr),
      .cpu_paused        (cpu_paused),
      .reset_PC          (reset_PC),
      .iRAM_write_enable (iRAM_write_enable),
      .extern_iRAM_addr  (extern_iRAM_addr),
      .iRAM_data_in      (iRAM_data_in),
      .load_error        (load_error),
      .words_loaded      (words_loaded)
   );

   // iRAM model and activity monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (iRAM_write_enable && data_ack) begin
         mem[extern_iRAM_addr] = iRAM_data_in;
         write_cnt++;
      end
      if (packet_ack && !ack_prev)
         ack_rises++;
      ack_prev = packet_ack;
      if (reset_PC)
         reset_pc_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      while (packet_ack && n < 100) begin @(negedge clk); n++; end
      if (packet_ack) check("ack_idle_timeout", {31'd0, packet_ack}, 32'd0);
      uart_packet  = b;
      packet_ready = 1'b1;
      n = 0;
      while (!packet_ack && n < 100) begin @(negedge clk); n++; end
      if (!packet_ack) check("ack_set_timeout", {31'd0, packet_ack}, 32'd1);
      packet_ready = 1'b0;
      n = 0;
      while (packet_ack && n < 100) begin @(negedge clk); n++; end
      if (packet_ack) check("ack_clr_timeout", {31'd0, packet_ack}, 32'd0);
   endtask

   task automatic send_word(input logic [23:0] w);
      logic [23:0] v;
      v = w;
      $display("send word %h", v);
      send_byte(v[7:0]);
      send_byte(v[15:8]);
      send_byte(v[23:16]);
   endtask

   int wc;
   int acks0;
   int n;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 24'h0;
      rst          = 1'b1;
      HALT_flag    = 1'b1;
      packet_ready = 1'b0;
      uart_packet  = 8'h00;
      data_ack     = 1'b1;
      PC_addr      = 8'h00;
      idle(3);
      rst = 1'b0;
      idle(1);

      // Reset values
      check("rst_ack",     {31'd0, packet_ack}, 32'd0);
      check("rst_paused",  {31'd0, cpu_paused}, 32'd0);
      check("rst_resetpc", {31'd0, reset_PC}, 32'd0);
      check("rst_we",      {31'd0, iRAM_write_enable}, 32'd0);
      check("rst_addr",    {24'd0, extern_iRAM_addr}, 32'd0);
      check("rst_data",    {8'd0, iRAM_data_in}, 32'd0);
      check("rst_err",     {31'd0, load_error}, 32'd0);
      check("rst_words",   {23'd0, words_loaded}, 32'd0);

      // Data word with no session open is discarded but still handshaked.
      acks0 = ack_rises;
      wc    = write_cnt;
      send_word(24'h112233);
      idle(5);
      check("nosess_acks",   ack_rises - acks0, 32'd3);
      check("nosess_writes", write_cnt - wc, 32'd0);
      check("nosess_paused", {31'd0, cpu_paused}, 32'd0);

      // Overflow: write at 0xFF, next data word dropped.
      wc = write_cnt;
      send_word(24'hFF0000);
      check("start_paused", {31'd0, cpu_paused}, 32'd1);
      send_word(24'hFFA0FF);
      send_word(24'h5A5A01);
      idle(5);
      check("ovf_err_first", {31'd0, load_error}, 32'd0);
      check("ovf_addr_hold", {24'd0, extern_iRAM_addr}, 32'hFF);
      send_word(24'h5A5A02);
      idle(5);
      check("ovf_mem_ff",  {8'd0, mem[8'hFF]}, 32'h5A5A01);
      check("ovf_writes",  write_cnt - wc, 32'd1);
      check("ovf_err",     {31'd0, load_error}, 32'd1);
      check("ovf_words",   {23'd0, words_loaded}, 32'd1);

      // Soft reset in the middle of a stalled write.
      send_word(24'hFFA020);
      data_ack = 1'b0;
      wc = write_cnt;
      send_word(24'h0A0B0C);
      n = 0;
      while (!iRAM_write_enable && n < 20) begin @(negedge clk); n++; end
      check("halt_we_up", {31'd0, iRAM_write_enable}, 32'd1);
      check("halt_data",  {8'd0, iRAM_data_in}, 32'h0A0B0C);
      idle(3);
      check("halt_we_hold", {31'd0, iRAM_write_enable}, 32'd1);
      HALT_flag = 1'b0;
      idle(1);
      check("halt_we_clr",  {31'd0, iRAM_write_enable}, 32'd0);
      check("halt_addr",    {24'd0, extern_iRAM_addr}, 32'h20);
      check("halt_paused",  {31'd0, cpu_paused}, 32'd0);
      check("halt_err_ret", {31'd0, load_error}, 32'd1);
      check("halt_words",   {23'd0, words_loaded}, 32'd1);
      check("halt_writes",  write_cnt - wc, 32'd0);
      HALT_flag = 1'b1;
      data_ack  = 1'b1;
      idle(2);

      // Basic load with END_KEEP (K = checksum of the two data words).
      reset_pc_seen = 1'b0;
      wc = write_cnt;
      send_word(24'hFF0000);
      check("load_paused", {31'd0, cpu_paused}, 32'd1);
      check("load_words0", {23'd0, words_loaded}, 32'd0);
      check("load_err0",   {31'd0, load_error}, 32'd0);
      send_word(24'h123456);
      send_word(24'hABCDEF);
      send_word(24'hFFF0F9);
      idle(5);
      check("load_mem0",    {8'd0, mem[0]}, 32'h123456);
      check("load_mem1",    {8'd0, mem[1]}, 32'hABCDEF);
      check("load_writes",  write_cnt - wc, 32'd2);
      check("load_words",   {23'd0, words_loaded}, 32'd2);
      check("load_unpause", {31'd0, cpu_paused}, 32'd0);
      check("load_nopcrst", {31'd0, reset_pc_seen}, 32'd0);

      // Relocated load with END_RESET waiting on the PC.
      send_word(24'hFF0000);
      send_word(24'hFFA040);
      PC_addr = 8'h17;
      send_word(24'hC0FFEE);
      idle(3);
      send_word(24'hFFFFD1);
      n = 0;
      while (!reset_PC && n < 20) begin @(negedge clk); n++; end
      idle(5);
      check("rst_pc_mem40",  {8'd0, mem[8'h40]}, 32'hC0FFEE);
      check("rst_pc_held",   {31'd0, reset_PC}, 32'd1);
      check("rst_pc_paused", {31'd0, cpu_paused}, 32'd1);
      PC_addr = 8'h00;
      idle(1);
      check("rst_pc_clr",     {31'd0, reset_PC}, 32'd0);
      check("rst_pc_unpause", {31'd0, cpu_paused}, 32'd0);
      idle(2);

`ifdef LOADER_CHECKSUM_EN
      send_word(24'hFF0000);
      send_word(24'h010203);
      send_word(24'hFFF000);
      idle(5);
      check("cks_good_err", {31'd0, load_error}, 32'd0);
      send_word(24'hFF0000);
      send_word(24'h010203);
      send_word(24'hFFF055);
      idle(5);
      check("cks_bad_err",    {31'd0, load_error}, 32'd1);
      check("cks_bad_paused", {31'd0, cpu_paused}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
